// File: rtl/cell_edit_ctrl.sv
// Cell board edit controller: cursor moves, window follow,
// and read-modify-write toggling of the cell under the cursor.
module cell_edit_ctrl #(
   parameter int   BOARD_DIM = 64,
   parameter logic MODE_EDIT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_toggle,
   input  logic [7:0] visi_cell_num,
   input  logic       cell_rd_data,
   input  logic       wr_ready,
   output logic [7:0] cur_x,
   output logic [7:0] cur_y,
   output logic [7:0] win_x,
   output logic [7:0] win_y,
   output logic [7:0] cell_addr_x,
   output logic [7:0] cell_addr_y,
   output logic       wr_en,
   output logic       wr_data,
   output logic       busy
);

   localparam logic [8:0] DIM9 = 9'(BOARD_DIM);
   localparam logic [7:0] MAXC = 8'(BOARD_DIM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR
   } st_t;

   st_t        r_st;
   logic [7:0] r_cx, r_cy, r_wx, r_wy;
   logic [7:0] r_ax, r_ay;
   logic       r_we, r_wd, r_busy;

   logic [8:0] w_vis;
   logic [7:0] w_nx, w_ny;
   logic       w_acc, w_tog;

   always_comb begin
      if (visi_cell_num == 8'd0)
         w_vis = 9'd1;
      else if ({1'b0, visi_cell_num} > DIM9)
         w_vis = DIM9;
      else
         w_vis = {1'b0, visi_cell_num};
   end

   // Slide the window just enough to keep the cursor visible, then clamp.
   function automatic logic [7:0] follow(
      input logic [7:0] c,
      input logic [7:0] w,
      input logic [8:0] v
   );
      logic [8:0] c9, w9, n9, lim;
      c9 = {1'b0, c};
      w9 = {1'b0, w};
      if (c9 < w9)
         n9 = c9;
      else if (c9 >= w9 + v)
         n9 = c9 - v + 9'd1;
      else
         n9 = w9;
      lim = DIM9 - v;
      if (n9 > lim)
         n9 = lim;
      return 8'(n9);
   endfunction

   assign w_acc = (mode == MODE_EDIT) && (r_st == S_IDLE);

   always_comb begin
      w_nx  = r_cx;
      w_ny  = r_cy;
      w_tog = 1'b0;
      if (w_acc) begin
         if (btn_toggle)
            w_tog = 1'b1;
         else if (btn_up)
            w_ny = (r_cy == 8'd0) ? MAXC : r_cy - 8'd1;
         else if (btn_down)
            w_ny = (r_cy == MAXC) ? 8'd0 : r_cy + 8'd1;
         else if (btn_left)
            w_nx = (r_cx == 8'd0) ? MAXC : r_cx - 8'd1;
         else if (btn_right)
            w_nx = (r_cx == MAXC) ? 8'd0 : r_cx + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cx <= '0;
         r_cy <= '0;
         r_wx <= '0;
         r_wy <= '0;
      end else begin
         r_cx <= w_nx;
         r_cy <= w_ny;
         r_wx <= follow(r_cx, r_wx, w_vis);
         r_wy <= follow(r_cy, r_wy, w_vis);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_st   <= S_IDLE;
         r_ax   <= '0;
         r_ay   <= '0;
         r_we   <= 1'b0;
         r_wd   <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         unique case (r_st)
            S_IDLE: begin
               r_ax <= w_nx;
               r_ay <= w_ny;
               if (w_tog) begin
                  r_st   <= S_RD;
                  r_busy <= 1'b1;
               end
            end
            S_RD: r_st <= S_CAP;
            S_CAP: begin
               r_wd <= ~cell_rd_data;
               r_we <= 1'b1;
               r_st <= S_WR;
            end
            S_WR: begin
               if (wr_ready) begin
                  r_we   <= 1'b0;
                  r_busy <= 1'b0;
                  r_st   <= S_IDLE;
               end
            end
            default: r_st <= S_IDLE;
         endcase
      end
   end

   assign cur_x       = r_cx;
   assign cur_y       = r_cy;
   assign win_x       = r_wx;
   assign win_y       = r_wy;
   assign cell_addr_x = r_ax;
   assign cell_addr_y = r_ay;
   assign wr_en       = r_we;
   assign wr_data     = r_wd;
   assign busy        = r_busy;

endmodule

// File: tb/tb_cell_edit_ctrl.sv
// Directed bench for cell_edit_ctrl: moves, window follow,
// toggle handshake, gating and asynchronous reset.
module tb_cell_edit_ctrl;

   localparam logic [4:0] B_TOG = 5'b10000;
   localparam logic [4:0] B_UP  = 5'b01000;
   localparam logic [4:0] B_DN  = 5'b00100;
   localparam logic [4:0] B_LF  = 5'b00010;
   localparam logic [4:0] B_RT  = 5'b00001;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic [4:0] btn;
   logic [7:0] vis;
   logic       rd_data;
   logic       wr_ready;
   logic [7:0] cur_x, cur_y, win_x, win_y;
   logic [7:0] ax, ay;
   logic       wr_en, wr_data, busy;

   int n_chk = 0;
   int n_err = 0;
   int n_wr  = 0;
   int cnt;

   cell_edit_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .btn_up       (btn[3]),
      .btn_down     (btn[2]),
      .btn_left     (btn[1]),
      .btn_right    (btn[0]),
      .btn_toggle   (btn[4]),
      .visi_cell_num(vis),
      .cell_rd_data (rd_data),
      .wr_ready     (wr_ready),
      .cur_x        (cur_x),
      .cur_y        (cur_y),
      .win_x        (win_x),
      .win_y        (win_y),
      .cell_addr_x  (ax),
      .cell_addr_y  (ay),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (wr_en && wr_ready) n_wr++;

   task automatic check(input string tag,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic press(input logic [4:0] b);
      btn = b;
      @(negedge clk);
      btn = 5'b0;
   endtask

   task automatic finish_toggle();
      int k;
      wr_ready = 1'b1;
      k = 0;
      while (busy && k < 10) begin
         @(negedge clk);
         k++;
      end
      wr_ready = 1'b0;
      check("toggle_done", 32'(busy), 32'd0);
   endtask

   initial begin
      rst      = 1'b0;
      mode     = 1'b1;
      btn      = 5'b0;
      vis      = 8'd16;
      rd_data  = 1'b0;
      wr_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cur", 32'({cur_x, cur_y}), 32'd0);
      check("rst_win", 32'({win_x, win_y}), 32'd0);
      check("rst_out", 32'({wr_en, wr_data, busy, ax, ay}), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      press(B_LF);
      check("wrap_left", 32'(cur_x), 32'd63);
      check("wrap_win_lag", 32'(win_x), 32'd0);
      @(negedge clk);
      check("wrap_win", 32'(win_x), 32'd48);
      press(B_RT);
      check("wrap_right", 32'(cur_x), 32'd0);
      @(negedge clk);
      check("wrap_win0", 32'(win_x), 32'd0);

      repeat (16) press(B_DN);
      check("scroll_cur", 32'(cur_y), 32'd16);
      @(negedge clk);
      check("scroll_win", 32'(win_y), 32'd1);
      vis = 8'd0;
      @(negedge clk);
      check("vis0_win", 32'(win_y), 32'd16);
      vis = 8'd16;

      repeat (5) press(B_RT);
      repeat (9) press(B_UP);
      check("pos", 32'({cur_x, cur_y}), {16'd0, 8'd5, 8'd7});

      rd_data = 1'b0;
      press(B_TOG);
      check("rd_busy", 32'(busy), 32'd1);
      check("rd_addr", 32'({ax, ay}), {16'd0, 8'd5, 8'd7});
      check("rd_we", 32'(wr_en), 32'd0);
      @(negedge clk);
      check("cap_addr", 32'({ax, ay}), {16'd0, 8'd5, 8'd7});
      @(negedge clk);
      check("wr_data", 32'(wr_data), 32'd1);
      check("wr_addr", 32'({ax, ay}), {16'd0, 8'd5, 8'd7});
      cnt = 0;
      repeat (4) begin
         if (wr_en) cnt++;
         @(negedge clk);
      end
      wr_ready = 1'b1;
      if (wr_en) cnt++;
      @(negedge clk);
      wr_ready = 1'b0;
      check("we_cycles", 32'(cnt), 32'd5);
      check("we_drop", 32'(wr_en), 32'd0);
      check("busy_drop", 32'(busy), 32'd0);
      check("wr_count1", 32'(n_wr), 32'd1);

      press(B_TOG | B_RT);
      check("cont_busy", 32'(busy), 32'd1);
      check("cont_x", 32'(cur_x), 32'd5);
      press(B_UP);
      check("busy_up", 32'(cur_y), 32'd7);
      finish_toggle();
      check("wr_count2", 32'(n_wr), 32'd2);

      mode = 1'b0;
      press(5'b11111);
      check("gate_cur", 32'({cur_x, cur_y}), {16'd0, 8'd5, 8'd7});
      check("gate_busy", 32'(busy), 32'd0);
      mode = 1'b1;

      rd_data = 1'b1;
      press(B_TOG);
      @(negedge clk);
      mode = 1'b0;
      @(negedge clk);
      check("mdrop_we", 32'(wr_en), 32'd1);
      check("mdrop_data", 32'(wr_data), 32'd0);
      finish_toggle();
      check("wr_count3", 32'(n_wr), 32'd3);
      mode = 1'b1;

      rd_data = 1'b0;
      press(B_TOG);
      repeat (2) @(negedge clk);
      check("pre_rst_we", 32'(wr_en), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_we", 32'(wr_en), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_cur", 32'({cur_x, cur_y}), 32'd0);
      check("async_win", 32'({win_x, win_y}), 32'd0);
      wr_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      wr_ready = 1'b0;
      check("post_rst_we", 32'(wr_en), 32'd0);
      check("post_rst_wr", 32'(n_wr), 32'd3);

      press(B_UP);
      check("wrap_up", 32'(cur_y), 32'd63);
      @(negedge clk);
      check("wrap_up_win", 32'(win_y), 32'd48);
      vis = 8'd200;
      @(negedge clk);
      check("vis_big_win", 32'(win_y), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cell_edit_ctrl.md
Name: cell_edit_ctrl

Overview:
Edit-mode producer for the cell board. It owns the cursor (cur_x/cur_y) and viewport origin (win_x/win_y) consumed by the display controller. It converts single-cycle button pulses into cursor moves. It also toggles the cell under the cursor through a read-modify-write on the cell memory port. It sits between the button debouncers and the cell memory, alongside the display controller.

Parameters:
BOARD_DIM, 64, board edge length in cells; cursor and window coordinates are in 0..BOARD_DIM-1.
MODE_EDIT, 1'b1, value of mode that enables editing (matches `MODE_EDIT).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
mode  input  1  run/edit mode; editing only when mode == MODE_EDIT
btn_up  input  1  one-cycle pulse, cursor y-1
btn_down  input  1  one-cycle pulse, cursor y+1
btn_left  input  1  one-cycle pulse, cursor x-1
btn_right  input  1  one-cycle pulse, cursor x+1
btn_toggle  input  1  one-cycle pulse, invert cell at cursor
visi_cell_num  input  8  visible cells per axis, same value fed to the display controller
cell_rd_data  input  1  memory read data; valid exactly one cycle after the address is presented
wr_ready  input  1  memory accepts the write in any cycle where wr_en && wr_ready
cur_x, cur_y  output  `ADDR_WIDTH (8)  cursor position
win_x, win_y  output  `ADDR_WIDTH (8)  viewport origin
cell_addr_x, cell_addr_y  output  `ADDR_WIDTH (8)  memory address for read and write
wr_en  output  1  write request
wr_data  output  1  new cell state
busy  output  1  toggle in progress

Behaviour:
- Reset (rst low, async): all outputs 0. FSM goes to IDLE. wr_en drops immediately, including mid-write; the partial toggle is abandoned.
- vis_eff = visi_cell_num clamped to [1, BOARD_DIM]. A value of 0 is treated as 1.
- Input gating: all button pulses are ignored unless mode == MODE_EDIT and the FSM is in IDLE.
- Moves:
  - Priority when several are asserted in one cycle: toggle > up > down > left > right. Exactly one action is taken; the rest are dropped.
  - The cursor register updates on the clock edge that samples the pulse.
  - Wrap-around: x-1 from 0 gives BOARD_DIM-1; x+1 from BOARD_DIM-1 gives 0. The y axis behaves the same way.
- Window follow (per axis, registered, one cycle after the cursor changes):
  - If cur < win, then win = cur.
  - Else if cur >= win + vis_eff, then win = cur - vis_eff + 1.
  - Afterwards, clamp win to <= BOARD_DIM - vis_eff.
  - Recomputed every cycle, so a change to visi_cell_num also re-clamps the window. Compute with 9-bit intermediates; no 8-bit overflow is allowed.
- Toggle FSM:
  - IDLE: on an accepted toggle, latch cell_addr = {cur_x, cur_y}, go to RD, busy=1.
  - RD: address is stable on cell_addr; go to CAP.
  - CAP: capture wr_data = ~cell_rd_data; go to WR.
  - WR: wr_en=1 and held until wr_ready. On the wr_ready cycle, go to IDLE with wr_en=0 and busy=0 on the next edge.
  - Minimum latency from pulse to write accept is 3 cycles (pulse edge → RD → CAP → WR with wr_ready=1).
- cell_addr is held constant from RD through WR. In IDLE it tracks {cur_x, cur_y}.
- If mode leaves MODE_EDIT mid-toggle, the toggle still completes; memory must not be left inconsistent.
- busy = (state != IDLE).
- Width: coordinates are 8 bits; BOARD_DIM <= 256.

Test Plan:
- Reset: drive rst low mid-WR with wr_en=1 → wr_en=0 the same cycle; cur, win, busy all 0; no write accepted after release.
- Wrap: cur_x=0, win_x=0, vis=16, btn_left → cur_x=63 next cycle, win_x=48 one cycle later. Then btn_right → cur_x=0, then win_x=0.
- Scroll: vis=16, win_y=0, press btn_down 16 times from cur_y=0 → cur_y=16, win_y=1. Set visi_cell_num=0 → vis_eff=1, win_y becomes 16.
- Toggle: cur=(5,7), cell_rd_data=0, wr_ready held low 4 cycles then high → addr=(5,7) from RD to WR; wr_data=1; wr_en high for 5 cycles; busy low the cycle after accept.
- Contention: btn_toggle and btn_right in the same cycle → toggle runs and the cursor is unchanged. btn_up during busy → ignored, cur_y unchanged.
- Mode gating: mode=0 with all buttons pulsed → no change. Mode drops in CAP → write still issued with the correct data.
